execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//   Execute stage of the 16-bit five-stage pipeline. Consumes the registered decode outputs:
//   ALU op, carry select, control bits, two register operands, sign-extended immediate and
//   destination address. Computes the ALU result and maintains the condition-code register
//   (CCR: Z,N,C). Drives the EX/MEM pipeline register, with stall and flush for hazard control.
// PARAMETERS
//   WIDTH     16   datapath width; operands, immediate and result
//   ADDR_W    3    register-file address width
// PORTS
//   clk                  in   1      rising-edge clock
//   rst                  in   1      synchronous, active-high reset
//   in_valid             in   1      decode slot holds a real instruction (0 = bubble)
//   ALUOp                in   2      00 ADD, 01 SUB, 10 AND, 11 PASS (op2)
//   carrySelect          in   2      00 C from ALU, 01 keep C, 10 set C=1, 11 clear C=0
//   alu_src_imm          in   1      1: op2 = sign_extend_in, 0: op2 = reg_data2
//   WB_ALUtoReg, RegWrite, MemRead, MemWrite  in 1 each  control bits, carried to EX/MEM
//   reg_data1            in   WIDTH  operand 1
//   reg_data2            in   WIDTH  operand 2; also the store data
//   sign_extend_in       in   WIDTH  sign-extended immediate
//   reg_write_address    in   ADDR_W destination register
//   stall                in   1      hold EX/MEM register and CCR
//   flush                in   1      replace this cycle's instruction with a bubble
//   alu_result_r         out  WIDTH  registered ALU result
//   store_data_r         out  WIDTH  registered reg_data2
//   WB_ALUtoReg_r, RegWrite_r, MemRead_r, MemWrite_r  out 1 each  registered control bits
//   reg_write_address_r  out  ADDR_W registered destination
//   valid_r              out  1      registered slot valid
//   ccr_r                out  3      {Z,N,C} flag register
// BEHAVIOUR
//   - Reset: all outputs, including ccr_r, are 0 on the first edge with rst=1. rst beats flush and stall.
//   - Latency: 1 cycle. Inputs sampled at edge k appear on *_r after edge k.
//   - op2 = alu_src_imm ? sign_extend_in : reg_data2. store_data_r is always reg_data2.
//   - Arithmetic uses a (WIDTH+1)-bit sum; results wrap modulo 2^WIDTH.
//     ADD: {c,res} = op1 + op2; c = carry-out.
//     SUB: res = op1 - op2; c = 1 iff op1 < op2 unsigned (borrow).
//     AND: res = op1 & op2; no ALU carry.
//     PASS: res = op2; no ALU carry.
//   - Flag update applies only when in_valid=1, stall=0 and flush=0 (call this "commit").
//   - Z,N: on commit with ADD/SUB/AND, Z=(res==0) and N=res[WIDTH-1]. PASS leaves Z,N unchanged.
//   - C on commit:
//     carrySelect=00: C takes c for ADD/SUB and is unchanged for AND/PASS.
//     carrySelect=01: C is kept. 10: C=1. 11: C=0.
//   - stall=1, flush=0: every *_r output and ccr_r holds its value.
//   - flush=1: EX/MEM register loads a bubble regardless of stall. A bubble is
//     valid_r=0, all control bits 0, alu_result_r=0, store_data_r=0, address 0. ccr_r holds.
//   - in_valid=0, no stall, no flush: a bubble is loaded as above and ccr_r holds.
//   - Outputs are registered only; no combinational path from inputs to outputs.
//   - Back-to-back dependent instructions see the CCR from the previous commit. No internal forwarding.
// TESTING
//   - Reset: rst=1 for 2 cycles with random inputs -> all *_r=0, ccr_r=000. Release -> first valid op propagates after 1 edge.
//   - ADD overflow: 0xFFFF + 0x0001, carrySelect=00, RegWrite=1 -> alu_result_r=0x0000, ccr_r=Z1 N0 C1, RegWrite_r=1.
//   - SUB borrow, immediate: op1=0x0003, alu_src_imm=1, imm=0xFFFB (-5) -> result 0x0008, C=1 (3<0xFFFB), N=0, Z=0.
//     Then SUB 5-5 -> result 0x0000, Z=1, C=0.
//   - Carry select: SETC (PASS, cs=10) -> C=1, Z/N unchanged. AND 0x8000&0xFFFF, cs=00 -> N=1, C stays 1. CLRC -> C=0.
//   - Stall/flush: valid ADD with stall=1 for 3 cycles -> outputs and CCR frozen.
//     flush=1 together with stall=1 -> valid_r=0, controls 0, ccr_r unchanged.
//   - Bubble: in_valid=0 with MemWrite=1, 0xFFFF+1 -> MemWrite_r=0, valid_r=0, ccr_r unchanged.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage: ALU, condition-code register and EX/MEM pipeline register with stall/flush
module execute_stage #(
  parameter int WIDTH = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        ALUOp,
  input  logic [1:0]        carrySelect,
  input  logic              alu_src_imm,
  input  logic              WB_ALUtoReg,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [WIDTH-1:0]  reg_data1,
  input  logic [WIDTH-1:0]  reg_data2,
  input  logic [WIDTH-1:0]  sign_extend_in,
  input  logic [ADDR_W-1:0] reg_write_address,
  input  logic              stall,
  input  logic              flush,
  output logic [WIDTH-1:0]  alu_result_r,
  output logic [WIDTH-1:0]  store_data_r,
  output logic              WB_ALUtoReg_r,
  output logic              RegWrite_r,
  output logic              MemRead_r,
  output logic              MemWrite_r,
  output logic [ADDR_W-1:0] reg_write_address_r,
  output logic              valid_r,
  output logic [2:0]        ccr_r
);
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             alu_c;
  logic             arith;
  logic             commit;
  logic [2:0]       ccr_next;
  // ALU result, ALU carry/borrow and the flag values a commit would write
  always_comb begin
    op2 = alu_src_imm ? sign_extend_in : reg_data2;
    sum = {1'b0, reg_data1} + {1'b0, op2};
    diff = {1'b0, reg_data1} - {1'b0, op2};
    arith = ~ALUOp[1];
    alu_c = ALUOp[0] ? diff[WIDTH] : sum[WIDTH];
    res = ALUOp == 2'b00 ? sum[WIDTH-1:0] :
          ALUOp == 2'b01 ? diff[WIDTH-1:0] :
          ALUOp == 2'b10 ? (reg_data1 & op2) : op2;
    commit = in_valid & ~stall & ~flush;
    ccr_next[2] = ALUOp == 2'b11 ? ccr_r[2] : (res == '0);
    ccr_next[1] = ALUOp == 2'b11 ? ccr_r[1] : res[WIDTH-1];
    ccr_next[0] = carrySelect == 2'b00 ? (arith ? alu_c : ccr_r[0]) :
                  carrySelect == 2'b01 ? ccr_r[0] : ~carrySelect[0];
  end
  // EX/MEM register: flush or an idle slot loads a bubble, stall holds
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !in_valid)) begin
      alu_result_r <= '0;
      store_data_r <= '0;
      WB_ALUtoReg_r <= 1'b0;
      RegWrite_r <= 1'b0;
      MemRead_r <= 1'b0;
      MemWrite_r <= 1'b0;
      reg_write_address_r <= '0;
      valid_r <= 1'b0;
    end else if (!stall) begin
      alu_result_r <= res;
      store_data_r <= reg_data2;
      WB_ALUtoReg_r <= WB_ALUtoReg;
      RegWrite_r <= RegWrite;
      MemRead_r <= MemRead;
      MemWrite_r <= MemWrite;
      reg_write_address_r <= reg_write_address;
      valid_r <= 1'b1;
    end
  end
  // condition codes change only when a real instruction commits
  always_ff @(posedge clk) begin
    if (rst) ccr_r <= '0;
    else if (commit) ccr_r <= ccr_next;
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and randomized checks of execute_stage against an arithmetic model
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, alu_src_imm, WB_ALUtoReg, RegWrite, MemRead, MemWrite, stall, flush;
  logic [1:0]  ALUOp, carrySelect;
  logic [15:0] reg_data1, reg_data2, sign_extend_in;
  logic [2:0]  reg_write_address;
  logic [15:0] alu_result_r, store_data_r;
  logic        WB_ALUtoReg_r, RegWrite_r, MemRead_r, MemWrite_r, valid_r;
  logic [2:0]  reg_write_address_r, ccr_r;
  logic [15:0] m_res, m_sd;
  logic [3:0]  m_ctl;
  logic [2:0]  m_addr, m_ccr;
  logic        m_valid;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  execute_stage #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ALUOp(ALUOp), .carrySelect(carrySelect),
    .alu_src_imm(alu_src_imm), .WB_ALUtoReg(WB_ALUtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .reg_data1(reg_data1), .reg_data2(reg_data2),
    .sign_extend_in(sign_extend_in), .reg_write_address(reg_write_address),
    .stall(stall), .flush(flush), .alu_result_r(alu_result_r), .store_data_r(store_data_r),
    .WB_ALUtoReg_r(WB_ALUtoReg_r), .RegWrite_r(RegWrite_r), .MemRead_r(MemRead_r),
    .MemWrite_r(MemWrite_r), .reg_write_address_r(reg_write_address_r),
    .valid_r(valid_r), .ccr_r(ccr_r)
  );

  function automatic logic [42:0] dut_v();
    return {alu_result_r, store_data_r, WB_ALUtoReg_r, RegWrite_r, MemRead_r, MemWrite_r,
            reg_write_address_r, valid_r, ccr_r};
  endfunction

  function automatic logic [42:0] mod_v();
    return {m_res, m_sd, m_ctl, m_addr, m_valid, m_ccr};
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] cs, input logic imm,
                       input logic [3:0] ctl, input logic [15:0] d1, input logic [15:0] d2,
                       input logic [15:0] se, input logic [2:0] ad);
    in_valid = v; ALUOp = op; carrySelect = cs; alu_src_imm = imm;
    {WB_ALUtoReg, RegWrite, MemRead, MemWrite} = ctl;
    reg_data1 = d1; reg_data2 = d2; sign_extend_in = se; reg_write_address = ad;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    int a, b, r, c;
    @(posedge clk);
    if (rst) begin
      m_res = '0; m_sd = '0; m_ctl = '0; m_addr = '0; m_valid = 1'b0; m_ccr = '0;
    end else begin
      a = int'(reg_data1);
      b = alu_src_imm ? int'(sign_extend_in) : int'(reg_data2);
      c = -1;
      case (ALUOp)
        2'd0: begin r = (a + b) % 65536; c = (a + b > 65535) ? 1 : 0; end
        2'd1: begin r = (a - b + 65536) % 65536; c = (a < b) ? 1 : 0; end
        2'd2: r = a & b;
        default: r = b;
      endcase
      if (in_valid && !stall && !flush) begin
        if (ALUOp != 2'd3) begin
          m_ccr[2] = (r == 0);
          m_ccr[1] = (r >= 32768);
        end
        if (carrySelect == 2'd0 && c >= 0) m_ccr[0] = (c == 1);
        else if (carrySelect == 2'd2) m_ccr[0] = 1'b1;
        else if (carrySelect == 2'd3) m_ccr[0] = 1'b0;
      end
      if (flush || (!stall && !in_valid)) begin
        m_res = '0; m_sd = '0; m_ctl = '0; m_addr = '0; m_valid = 1'b0;
      end else if (!stall) begin
        m_res = r[15:0]; m_sd = reg_data2; m_addr = reg_write_address; m_valid = 1'b1;
        m_ctl = {WB_ALUtoReg, RegWrite, MemRead, MemWrite};
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 4'($urandom),
          16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
    stall = 1'($urandom); flush = 1'($urandom);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dut_v() !== 43'd0) begin
        errors++; $display("FAIL reset_zero got=%h exp=0", dut_v());
      end
    end
    rst = 1'b0;
    drive(1'b1, 2'b00, 2'b00, 1'b0, 4'b0100, 16'd2, 16'd3, 16'd0, 3'd5);
    tick();
    checks++;
    if (alu_result_r !== 16'd5 || valid_r !== 1'b1 || reg_write_address_r !== 3'd5) begin
      errors++; $display("FAIL reset_first_op res=%h valid=%b addr=%0d exp 0005/1/5", alu_result_r, valid_r, reg_write_address_r);
    end
    checks++;
    if (dut_v() !== mod_v()) begin
      errors++; $display("FAIL reset_model got=%h exp=%h", dut_v(), mod_v());
    end
  endtask

  task automatic test_add_overflow();
    drive(1'b1, 2'b00, 2'b00, 1'b0, 4'b0100, 16'hFFFF, 16'h0001, 16'h0000, 3'd1);
    tick();
    checks++;
    if (alu_result_r !== 16'h0000 || ccr_r !== 3'b101 || RegWrite_r !== 1'b1) begin
      errors++; $display("FAIL add_overflow res=%h ccr=%b rw=%b exp 0000/101/1", alu_result_r, ccr_r, RegWrite_r);
    end
    checks++;
    if (dut_v() !== mod_v()) begin
      errors++; $display("FAIL add_model got=%h exp=%h", dut_v(), mod_v());
    end
  endtask

  task automatic test_sub_imm();
    drive(1'b1, 2'b01, 2'b00, 1'b1, 4'b0100, 16'h0003, 16'h1234, 16'hFFFB, 3'd2);
    tick();
    checks++;
    if (alu_result_r !== 16'h0008 || ccr_r !== 3'b001 || store_data_r !== 16'h1234) begin
      errors++; $display("FAIL sub_borrow res=%h ccr=%b sd=%h exp 0008/001/1234", alu_result_r, ccr_r, store_data_r);
    end
    drive(1'b1, 2'b01, 2'b00, 1'b0, 4'b0100, 16'h0005, 16'h0005, 16'h0000, 3'd2);
    tick();
    checks++;
    if (alu_result_r !== 16'h0000 || ccr_r !== 3'b100) begin
      errors++; $display("FAIL sub_zero res=%h ccr=%b exp 0000/100", alu_result_r, ccr_r);
    end
  endtask

  task automatic test_carry_select();
    drive(1'b1, 2'b11, 2'b10, 1'b0, 4'b0000, 16'h0000, 16'h1234, 16'h0000, 3'd0);
    tick();
    checks++;
    if (alu_result_r !== 16'h1234 || ccr_r !== 3'b101) begin
      errors++; $display("FAIL setc res=%h ccr=%b exp 1234/101", alu_result_r, ccr_r);
    end
    drive(1'b1, 2'b10, 2'b00, 1'b0, 4'b0100, 16'h8000, 16'hFFFF, 16'h0000, 3'd4);
    tick();
    checks++;
    if (alu_result_r !== 16'h8000 || ccr_r !== 3'b011) begin
      errors++; $display("FAIL and_flags res=%h ccr=%b exp 8000/011", alu_result_r, ccr_r);
    end
    drive(1'b1, 2'b11, 2'b11, 1'b0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 3'd0);
    tick();
    checks++;
    if (ccr_r !== 3'b010) begin
      errors++; $display("FAIL clrc ccr=%b exp 010", ccr_r);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 2'b01, 2'b00, 1'b0, 4'b1110, 16'h0001, 16'h0002, 16'h0000, 3'd3);
    tick();
    checks++;
    if (alu_result_r !== 16'hFFFF || ccr_r !== 3'b011) begin
      errors++; $display("FAIL pre_stall res=%h ccr=%b exp FFFF/011", alu_result_r, ccr_r);
    end
    drive(1'b1, 2'b00, 2'b00, 1'b0, 4'b0101, 16'h0000, 16'h0000, 16'h0000, 3'd6);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (alu_result_r !== 16'hFFFF || ccr_r !== 3'b011 || valid_r !== 1'b1 || reg_write_address_r !== 3'd3
          || {WB_ALUtoReg_r, RegWrite_r, MemRead_r, MemWrite_r} !== 4'b1110) begin
        errors++; $display("FAIL stall_hold cyc=%0d got=%h exp res=FFFF ccr=011 addr=3 ctl=1110", i, dut_v());
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (dut_v() !== {40'd0, 3'b011}) begin
      errors++; $display("FAIL flush_stall got=%h exp=%h", dut_v(), {40'd0, 3'b011});
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, 2'b00, 2'b00, 1'b0, 4'b0001, 16'hFFFF, 16'h0001, 16'h0000, 3'd7);
    tick();
    checks++;
    if (MemWrite_r !== 1'b0 || valid_r !== 1'b0 || ccr_r !== 3'b011 || alu_result_r !== 16'h0000) begin
      errors++; $display("FAIL bubble mw=%b valid=%b ccr=%b res=%h exp 0/0/011/0000", MemWrite_r, valid_r, ccr_r, alu_result_r);
    end
    checks++;
    if (dut_v() !== mod_v()) begin
      errors++; $display("FAIL bubble_model got=%h exp=%h", dut_v(), mod_v());
    end
  endtask

  task automatic test_random();
    logic [15:0] pick [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(3) != 0), 2'($urandom), 2'($urandom), 1'($urandom), 4'($urandom),
            ($urandom_range(3) == 0) ? pick[$urandom_range(3)] : 16'($urandom),
            ($urandom_range(3) == 0) ? pick[$urandom_range(3)] : 16'($urandom),
            16'($urandom), 3'($urandom));
      stall = ($urandom_range(4) == 0);
      flush = ($urandom_range(7) == 0);
      rst = ($urandom_range(49) == 0);
      tick();
      checks++;
      if (dut_v() !== mod_v()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_v(), mod_v());
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b00, 2'b00, 1'b0, 4'b0100, 16'hFFFF, 16'hFFFF, 16'h0000, 3'd1);
    tick();
    drive(1'b1, 2'b00, 2'b01, 1'b0, 4'b0100, 16'h0001, 16'h0001, 16'h0000, 3'd2);
    tick();
    checks++;
    if (alu_result_r !== 16'h0002 || ccr_r !== 3'b001) begin
      errors++; $display("FAIL back_to_back_keepc res=%h ccr=%b exp 0002/001", alu_result_r, ccr_r);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_add_overflow();
    test_sub_imm();
    test_carry_select();
    test_stall_flush();
    test_bubble();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
